// File: rtl/edge_event_arbiter_pkg.sv
// Shared definitions for the edge-event arbiter: request index layout,
// scheduler states and the channel-index width helper.
package edge_event_arbiter_pkg;

    localparam int unsigned RISE_OFS = 0;
    localparam int unsigned FALL_OFS = 1;

    typedef enum logic {
        IDLE,
        PRESENT
    } state_e;

    function automatic int unsigned ch_width(input int unsigned ch_num);
        return (ch_num > 1) ? $clog2(ch_num) : 1;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event stream carrying the channel index and edge polarity.
interface edge_event_arbiter_if
    import edge_event_arbiter_pkg::*;
#(
    parameter int unsigned CH_NUM = 4
);
    localparam int unsigned CH_W = ch_width(CH_NUM);

    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;
    logic            evt_rise;

    modport master (output evt_valid, output evt_ch, output evt_rise, input evt_ready);
    modport slave  (input evt_valid, input evt_ch, input evt_rise, output evt_ready);

endinterface

// File: rtl/edge_event_arbiter_edge_detect_ch.sv
// One input line: SYNC_STAGES-deep synchronizer, delayed copy and
// combinational rise/fall detection on the synchronized level.
module edge_detect_ch #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_lvl;
    logic                   prev_q;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], in_i};
    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_lvl;
        end
    end

    assign rise_o = sync_lvl & ~prev_q;
    assign fall_o = ~sync_lvl & prev_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Latches enabled edges from CH_NUM async lines as pending requests and
// serializes them round-robin onto a single valid/ready event stream.
module edge_event_arbiter
    import edge_event_arbiter_pkg::*;
#(
    parameter int unsigned CH_NUM      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH_NUM-1:0]     in_i,
    input  logic [CH_NUM-1:0]     rise_en_i,
    input  logic [CH_NUM-1:0]     fall_en_i,
    output logic [2*CH_NUM-1:0]   pending_o,
    output logic                  ovf_o,
    edge_event_arbiter_if.master  evt
);

    localparam int unsigned N     = 2 * CH_NUM;
    localparam int unsigned CH_W  = ch_width(CH_NUM);
    localparam int unsigned IDX_W = CH_W + 1;

    // First set request strictly after `last`, wrapping around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0]     req,
                                                 input logic [IDX_W-1:0] last);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        int unsigned    start;
        int unsigned    k;
        start = 32'(last) + 1;
        if (start >= N) start = 0;
        dbl = {req, req};
        rot = N'(dbl >> start);
        k   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (rot[N-1-i]) k = N - 1 - i;
        end
        k = k + start;
        if (k >= N) k = k - N;
        return IDX_W'(k);
    endfunction

    logic [CH_NUM-1:0] rise_det;
    logic [CH_NUM-1:0] fall_det;
    logic [N-1:0]      det;
    logic [N-1:0]      clr;
    logic [N-1:0]      pending_q, pending_d;
    logic              ovf_q, ovf_d;
    logic [IDX_W-1:0]  win;
    logic              take;

    state_e            state_q;
    logic              valid_q;
    logic [CH_W-1:0]   ch_q;
    logic              rise_q;
    logic [IDX_W-1:0]  last_q;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        edge_detect_ch #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_det (
            .clk   (clk),
            .rst_n (rst_n),
            .in_i  (in_i[c]),
            .rise_o(rise_det[c]),
            .fall_o(fall_det[c])
        );
    end

    // A set on a bit being cleared in the same cycle is a fresh event, not an overflow.
    always_comb begin
        det = '0;
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            det[2*c+RISE_OFS] = rise_det[c] & rise_en_i[c];
            det[2*c+FALL_OFS] = fall_det[c] & fall_en_i[c];
        end
        win  = rr_pick(pending_q, last_q);
        take = (|pending_q) && ((state_q == IDLE) || evt.evt_ready);
        clr  = '0;
        if (take) clr[win] = 1'b1;
        pending_d = (pending_q & ~clr) | det;
        ovf_d     = |(det & pending_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            ch_q      <= '0;
            rise_q    <= 1'b0;
            last_q    <= IDX_W'(N - 1);
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            if (take) begin
                state_q <= PRESENT;
                valid_q <= 1'b1;
                ch_q    <= win[IDX_W-1:1];
                rise_q  <= (win[0] == 1'(RISE_OFS));
                last_q  <= win;
            end else if ((state_q == PRESENT) && evt.evt_ready) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
            end
        end
    end

    assign evt.evt_valid = valid_q;
    assign evt.evt_ch    = ch_q;
    assign evt.evt_rise  = rise_q;
    assign pending_o     = pending_q;
    assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench: cycle-level reference model plus directed and random stimulus.
module tb_edge_event_arbiter;

    localparam int unsigned CH = 4;
    localparam int unsigned S  = 2;
    localparam int unsigned N  = 2 * CH;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] in_v  = '0;
    logic [CH-1:0] ren   = '1;
    logic [CH-1:0] fen   = '1;
    logic          rdy   = 1'b0;
    logic [N-1:0]  pend;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    edge_event_arbiter_if #(.CH_NUM(CH)) ev ();
    assign ev.evt_ready = rdy;

    edge_event_arbiter #(
        .CH_NUM     (CH),
        .SYNC_STAGES(S)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_i     (in_v),
        .rise_en_i(ren),
        .fall_en_i(fen),
        .pending_o(pend),
        .ovf_o    (ovf),
        .evt      (ev)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: level history, pending set, round-robin server.
    logic [CH-1:0] lvl_q[$];
    logic [N-1:0]  m_pend = '0;
    bit            m_valid = 0;
    int            m_ch = 0;
    bit            m_rise = 0;
    int            m_last = N - 1;
    bit            m_ovf = 0;

    task automatic m_reset();
        lvl_q.delete();
        for (int i = 0; i <= S; i++) lvl_q.push_back('0);
        m_pend = '0; m_valid = 0; m_ch = 0; m_rise = 0; m_last = N - 1; m_ovf = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        logic [CH-1:0] sy, pv;
        logic [N-1:0]  det, clr;
        int            pick;
        if (!rst_n) begin
            m_reset();
        end else begin
            sy  = lvl_q[S-1];
            pv  = lvl_q[S];
            det = '0;
            for (int c = 0; c < CH; c++) begin
                if (sy[c] && !pv[c] && ren[c]) det[2*c]   = 1'b1;
                if (!sy[c] && pv[c] && fen[c]) det[2*c+1] = 1'b1;
            end
            clr = '0;
            if (m_pend != 0 && (!m_valid || rdy)) begin
                pick = -1;
                for (int k = 1; k <= N; k++)
                    if (pick < 0 && m_pend[(m_last + k) % N]) pick = (m_last + k) % N;
                clr[pick] = 1'b1;
                m_valid = 1;
                m_ch    = pick / 2;
                m_rise  = (pick % 2 == 0);
                m_last  = pick;
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
            m_ovf  = |(det & m_pend & ~clr);
            m_pend = (m_pend & ~clr) | det;
            lvl_q.push_front(in_v);
            void'(lvl_q.pop_back());
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("evt_valid", 32'(ev.evt_valid), 32'(m_valid));
            chk("evt_ch",    32'(ev.evt_ch),    32'(m_ch));
            chk("evt_rise",  32'(ev.evt_rise),  32'(m_rise));
            chk("pending",   32'(pend),         32'(m_pend));
            chk("ovf",       32'(ovf),          32'(m_ovf));
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic r);
        rst_n = 1'b0;
        in_v  = '0;
        rdy   = r;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int max);
        int n = 0;
        while (!ev.evt_valid && n < max) begin
            cyc();
            n++;
        end
        chk(name, 32'(ev.evt_valid), 32'd1);
    endtask

    initial begin
        int n_ovf, n_rise1, n_fall1, n_evt;
        m_reset();
        @(negedge clk);
        chk("rst_valid",   32'(ev.evt_valid), 32'd0);
        chk("rst_ch",      32'(ev.evt_ch),    32'd0);
        chk("rst_rise",    32'(ev.evt_rise),  32'd0);
        chk("rst_pending", 32'(pend),         32'd0);
        chk("rst_ovf",     32'(ovf),          32'd0);

        // Single edge latency on ch2.
        do_reset(1'b1);
        cyc(); cyc();
        in_v[2] = 1'b1;
        cyc();
        cyc();
        chk("lat_pend_e1", 32'(pend), 32'h00);
        cyc();
        chk("lat_pend_e2", 32'(pend), 32'h10);
        chk("lat_valid_e2", 32'(ev.evt_valid), 32'd0);
        cyc();
        chk("lat_valid_e3", 32'(ev.evt_valid), 32'd1);
        chk("lat_ch", 32'(ev.evt_ch), 32'd2);
        chk("lat_rise", 32'(ev.evt_rise), 32'd1);
        chk("lat_pend_e3", 32'(pend), 32'h00);
        cyc();
        chk("lat_valid_e4", 32'(ev.evt_valid), 32'd0);

        // Round-robin ordering.
        do_reset(1'b1);
        cyc();
        in_v = 4'b1001;
        wait_valid("rr_wait1", 10);
        chk("rr_first_ch", 32'(ev.evt_ch), 32'd0);
        cyc();
        chk("rr_second_ch", 32'(ev.evt_ch), 32'd3);
        chk("rr_second_v", 32'(ev.evt_valid), 32'd1);
        in_v = 4'b0000;
        cyc();
        wait_valid("rr_wait2", 10);
        chk("rr_fall_ch3", 32'(ev.evt_ch), 32'd3);
        chk("rr_fall_r3", 32'(ev.evt_rise), 32'd0);
        cyc();
        chk("rr_fall_ch0", 32'(ev.evt_ch), 32'd0);
        chk("rr_fall_r0", 32'(ev.evt_rise), 32'd0);

        // Backpressure then drain.
        do_reset(1'b0);
        cyc();
        in_v = 4'b0111;
        wait_valid("bp_wait", 10);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("bp_hold_ch", 32'(ev.evt_ch), 32'd0);
            chk("bp_hold_v", 32'(ev.evt_valid), 32'd1);
        end
        chk("bp_pend", 32'(pend), 32'h14);
        rdy = 1'b1;
        cyc();
        chk("bp_drain1", 32'(ev.evt_ch), 32'd1);
        cyc();
        chk("bp_drain2", 32'(ev.evt_ch), 32'd2);
        cyc();
        chk("bp_drain_end", 32'(ev.evt_valid), 32'd0);

        // Overflow on a still-pending rise.
        do_reset(1'b0);
        cyc();
        in_v[0] = 1'b1;
        wait_valid("ovf_wait", 10);
        n_ovf = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 12) in_v[1] = (i < 4 || i >= 8);
            cyc();
            if (ovf) n_ovf++;
        end
        chk("ovf_pulses", 32'(n_ovf), 32'd1);
        chk("ovf_pend", 32'(pend), 32'h0C);

        // Fall enable masked on ch1.
        do_reset(1'b1);
        fen[1] = 1'b0;
        cyc();
        n_rise1 = 0; n_fall1 = 0; n_ovf = 0;
        for (int i = 0; i < 18; i++) begin
            in_v[1] = (i < 4);
            cyc();
            if (ev.evt_valid && ev.evt_ch == 2'd1 && ev.evt_rise) n_rise1++;
            if (ev.evt_valid && ev.evt_ch == 2'd1 && !ev.evt_rise) n_fall1++;
            if (ovf) n_ovf++;
        end
        chk("en_rise_cnt", 32'(n_rise1), 32'd1);
        chk("en_fall_cnt", 32'(n_fall1), 32'd0);
        chk("en_ovf_cnt", 32'(n_ovf), 32'd0);
        fen = '1;

        // Asynchronous reset while presenting.
        do_reset(1'b0);
        cyc();
        in_v[3] = 1'b1;
        wait_valid("ar_wait", 10);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(ev.evt_valid), 32'd0);
        chk("ar_pending", 32'(pend), 32'd0);
        chk("ar_ch", 32'(ev.evt_ch), 32'd0);
        chk("ar_rise", 32'(ev.evt_rise), 32'd0);
        in_v = '0;
        @(negedge clk);
        rst_n = 1'b1;
        n_evt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (ev.evt_valid) n_evt++;
        end
        chk("ar_no_events", 32'(n_evt), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(3) == 0) in_v[c] = ~in_v[c];
            rdy = ($urandom_range(9) < 7);
            if ($urandom_range(49) == 0) begin
                ren = 4'($urandom);
                fen = 4'($urandom);
            end
            if (i == 2000) begin
                ren = '1;
                fen = '1;
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
